w_stage_grf: RTL and testbench
==============================

Name: w_stage_grf

Overview:
- Writeback stage plus general register file of the 5-stage MIPS pipeline; consumes the M/W pipeline register outputs (instruction, pc, ALU result, memory read word, extended immediate, HI/LO value).
- Decodes the W-stage instruction, selects and load-extends the writeback datum, and writes the 32x32 register file.
- Serves the two D-stage read ports and drives the W-stage forwarding pair (A3/WD) to the hazard unit.

Parameters:
- LINK_OFFSET, 8, value added to pc for jal/jalr link data.
- BYPASS, 1, 1 = same-cycle write-to-read internal forwarding on the read ports; 0 = read the array only.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- W_Instr  input  32  W-stage instruction word.
- W_pc  input  32  W-stage instruction address.
- W_C  input  32  ALU result / memory byte address.
- W_RD  input  32  raw aligned data-memory word.
- W_EXTout  input  32  extended immediate (lui value).
- W_HILO  input  32  HI or LO value selected upstream for mfhi/mflo.
- D_A1  input  5  read port 1 address (rs).
- D_A2  input  5  read port 2 address (rt).
- D_RD1  output  32  read port 1 data.
- D_RD2  output  32  read port 2 data.
- W_A3  output  5  destination register of the W instruction (0 when it writes nothing).
- W_WD  output  32  writeback datum (forwarding source).

Behaviour:
- Reset (reset=0): all 32 registers clear to 0 asynchronously; D_RD1/D_RD2 read 0 immediately; writes are blocked while reset is low.
- Decode, combinational from W_Instr:
  - R-type ALU (add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, sllv, srlv, srav) -> A3=rd, WD=W_C.
  - addi, addiu, andi, ori, xori, slti, sltiu -> A3=rt, WD=W_C.
  - lui -> A3=rt, WD=W_EXTout.
  - lw, lh, lhu, lb, lbu -> A3=rt, WD=load-extended W_RD.
  - jal -> A3=31, WD=W_pc+LINK_OFFSET.
  - jalr -> A3=rd, WD=W_pc+LINK_OFFSET.
  - mfhi, mflo -> A3=rd, WD=W_HILO.
  - All other instructions (stores, branches, j, jr, mult/div, mthi/mtlo, unknown) -> A3=0, WD=0.
- Load extend uses byte offset W_C[1:0]:
  - lb/lbu select byte W_RD[8*off+7:8*off], then sign- or zero-extend.
  - lh/lhu select the halfword given by W_C[1] (0 = low half), then sign- or zero-extend.
  - lw passes W_RD unchanged; W_C[1:0] is ignored and no alignment fault is raised.
- Write: on posedge clk with reset high, if A3 != 0, reg[A3] <= WD. Register 0 is never written and always reads 0.
- Read: combinational.
  - With BYPASS=1: if D_An == W_A3 and W_A3 != 0, D_RDn = W_WD; otherwise D_RDn = reg[D_An].
  - With BYPASS=0: D_RDn = reg[D_An].
- Latency: a write is visible through the array one cycle after the W instruction; with BYPASS=1 it is visible in the same cycle.
- Simultaneous events:
  - Both read ports may address the same register as the write; both get the bypass value.
  - A3=0 with either D_An=0 still returns 0.
- Reset mid-operation: contents clear on the falling edge of reset regardless of clk. The first write after release occurs on the first posedge with reset high.
- No stall or enable input: the W stage never stalls, and bubbles arrive as W_Instr=0 (sll $0), which produce no write.
- Arithmetic: pc+LINK_OFFSET is modulo 2^32.

Decomposition:
- Shared macro/package file holds:
  - opcode and funct constants for every instruction listed above;
  - writeback-select codes WB_C, WB_RD, WB_EXT, WB_PC8, WB_HILO, WB_NONE;
  - destination-select codes DST_RD, DST_RT, DST_RA.
- One sub-module, w_load_ext: combinational byte/half select and extend (inputs: raw word, offset, load type; output: 32-bit datum).

Test Plan:
- Reset: write several registers, then pull reset low mid-cycle -> all D_RD read 0 immediately, before any clk edge.
- ori $5,$0,0x1234 (W_C=0x1234): same cycle with D_A1=5 -> D_RD1=0x1234 (bypass); next cycle with the W slot empty -> D_RD1=0x1234 from the array.
- lb $6 with W_RD=0x80FF7F01 at offsets 0..3 -> 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80; lhu at W_C[1]=1 -> 0x000080FF; lh at W_C[1]=0 -> 0x00007F01.
- jal at W_pc=0x00003000 -> W_A3=31, W_WD=0x00003008, reg31=0x00003008 next cycle.
- addu $0,$1,$2 with W_C=0xDEADBEEF -> W_A3=0, reg0 stays 0, D_A1=0 reads 0.
- sw and beq in W -> W_A3=0, no register changes; mflo $7 with W_HILO=0x55AA -> reg7=0x55AA.

Source files
------------

// File: rtl/w_stage_grf_pkg.sv
// Shared decode constants for the writeback stage and register file:
// MIPS opcode/funct values plus the writeback, destination and load-type selects.
package w_stage_grf_pkg;

    // Primary opcodes, Instr[31:26]
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // SPECIAL funct codes, Instr[5:0]
    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [2:0] {
        WB_NONE,
        WB_C,
        WB_RD,
        WB_EXT,
        WB_PC8,
        WB_HILO
    } wb_sel_e;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT,
        DST_RA
    } dst_sel_e;

    typedef enum logic [2:0] {
        LD_W,
        LD_H,
        LD_HU,
        LD_B,
        LD_BU
    } ld_type_e;

    function automatic logic is_r_alu(input logic [5:0] funct);
        case (funct)
            FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
            FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU: is_r_alu = 1'b1;
            default:                         is_r_alu = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/w_stage_grf_load_ext.sv
// Byte/halfword select and sign/zero extension of the aligned memory word.
module w_load_ext
    import w_stage_grf_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  off_i,
    input  ld_type_e    ld_type_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        case (off_i)
            2'd0:    byte_v = word_i[7:0];
            2'd1:    byte_v = word_i[15:8];
            2'd2:    byte_v = word_i[23:16];
            default: byte_v = word_i[31:24];
        endcase
        half_v = off_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        case (ld_type_i)
            LD_B:    data_o = {{24{byte_v[7]}}, byte_v};
            LD_BU:   data_o = {24'd0, byte_v};
            LD_H:    data_o = {{16{half_v[15]}}, half_v};
            LD_HU:   data_o = {16'd0, half_v};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/w_stage_grf.sv
// MIPS writeback stage: decodes the W instruction, forms the writeback datum,
// writes the 32x32 register file and serves the two D-stage read ports.
module w_stage_grf
    import w_stage_grf_pkg::*;
#(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] W_Instr,
    input  logic [31:0] W_pc,
    input  logic [31:0] W_C,
    input  logic [31:0] W_RD,
    input  logic [31:0] W_EXTout,
    input  logic [31:0] W_HILO,
    input  logic [4:0]  D_A1,
    input  logic [4:0]  D_A2,
    output logic [31:0] D_RD1,
    output logic [31:0] D_RD2,
    output logic [4:0]  W_A3,
    output logic [31:0] W_WD
);

    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  rt;
    logic [4:0]  rd;
    wb_sel_e     wb_sel;
    dst_sel_e    dst_sel;
    ld_type_e    ld_type;
    logic [31:0] load_data;
    logic [31:0] regs_q [32];
    logic        unused_instr_bits;

    assign opcode = W_Instr[31:26];
    assign rt     = W_Instr[20:16];
    assign rd     = W_Instr[15:11];
    assign funct  = W_Instr[5:0];
    assign unused_instr_bits = ^{W_Instr[25:21], W_Instr[10:6]};

    always_comb begin
        wb_sel  = WB_NONE;
        dst_sel = DST_NONE;
        ld_type = LD_W;
        case (opcode)
            OP_SPECIAL: begin
                if (is_r_alu(funct)) begin
                    wb_sel  = WB_C;
                    dst_sel = DST_RD;
                end else if (funct == FN_JALR) begin
                    wb_sel  = WB_PC8;
                    dst_sel = DST_RD;
                end else if (funct == FN_MFHI || funct == FN_MFLO) begin
                    wb_sel  = WB_HILO;
                    dst_sel = DST_RD;
                end
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_SLTIU: begin
                wb_sel  = WB_C;
                dst_sel = DST_RT;
            end
            OP_LUI: begin
                wb_sel  = WB_EXT;
                dst_sel = DST_RT;
            end
            OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU: begin
                wb_sel  = WB_RD;
                dst_sel = DST_RT;
                case (opcode)
                    OP_LH:   ld_type = LD_H;
                    OP_LHU:  ld_type = LD_HU;
                    OP_LB:   ld_type = LD_B;
                    OP_LBU:  ld_type = LD_BU;
                    default: ld_type = LD_W;
                endcase
            end
            OP_JAL: begin
                wb_sel  = WB_PC8;
                dst_sel = DST_RA;
            end
            default: begin
                wb_sel  = WB_NONE;
                dst_sel = DST_NONE;
            end
        endcase
    end

    w_load_ext u_load_ext (
        .word_i    (W_RD),
        .off_i     (W_C[1:0]),
        .ld_type_i (ld_type),
        .data_o    (load_data)
    );

    // Instructions that write nothing report A3=0/WD=0 so the hazard unit ignores them.
    always_comb begin
        case (dst_sel)
            DST_RD:  W_A3 = rd;
            DST_RT:  W_A3 = rt;
            DST_RA:  W_A3 = REG_RA;
            default: W_A3 = 5'd0;
        endcase
        case (wb_sel)
            WB_C:    W_WD = W_C;
            WB_RD:   W_WD = load_data;
            WB_EXT:  W_WD = W_EXTout;
            WB_PC8:  W_WD = W_pc + LINK_OFFSET;
            WB_HILO: W_WD = W_HILO;
            default: W_WD = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (W_A3 != 5'd0) begin
            regs_q[W_A3] <= W_WD;
        end
    end

    // Bypass is suppressed in reset so the read ports show the cleared array.
    always_comb begin
        if (BYPASS && reset && W_A3 != 5'd0 && D_A1 == W_A3) begin
            D_RD1 = W_WD;
        end else begin
            D_RD1 = regs_q[D_A1];
        end
        if (BYPASS && reset && W_A3 != 5'd0 && D_A2 == W_A3) begin
            D_RD2 = W_WD;
        end else begin
            D_RD2 = regs_q[D_A2];
        end
    end

endmodule

// File: tb/tb_w_stage_grf.sv
// Self-checking bench for w_stage_grf: directed test-plan cases plus random
// instruction streams checked against a behavioural register-file model.
module tb_w_stage_grf;

  localparam int W = 101;

  logic        clk;
  logic        reset;
  logic [31:0] W_Instr, W_pc, W_C, W_RD, W_EXTout, W_HILO;
  logic [4:0]  D_A1, D_A2;
  logic [31:0] D_RD1, D_RD2;
  logic [4:0]  W_A3;
  logic [31:0] W_WD;

  logic [W-1:0] exp_q[$];
  logic [31:0]  m_regs [32];
  int           n_total;
  int           n_pass;

  w_stage_grf dut (
    .clk      (clk),
    .reset    (reset),
    .W_Instr  (W_Instr),
    .W_pc     (W_pc),
    .W_C      (W_C),
    .W_RD     (W_RD),
    .W_EXTout (W_EXTout),
    .W_HILO   (W_HILO),
    .D_A1     (D_A1),
    .D_A2     (D_A2),
    .D_RD1    (D_RD1),
    .D_RD2    (D_RD2),
    .W_A3     (W_A3),
    .W_WD     (W_WD)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endfunction

  // reference model: architectural meaning of each instruction
  function automatic void ref_wb(input logic [31:0] ins, pc, c, rdw, ext, hilo,
                                 output logic [4:0] a3, output logic [31:0] wd);
    int unsigned op, fn;
    logic [31:0] b, h;
    op = ins[31:26];
    fn = ins[5:0];
    b  = (rdw >> (8 * c[1:0])) & 32'hFF;
    h  = (rdw >> (16 * c[1])) & 32'hFFFF;
    a3 = 5'd0;
    wd = 32'd0;
    if (op == 0) begin
      if (fn inside {0, 2, 3, 4, 6, 7, [32:39], 42, 43}) begin a3 = ins[15:11]; wd = c; end
      else if (fn == 9) begin a3 = ins[15:11]; wd = pc + 32'd8; end
      else if (fn == 16 || fn == 18) begin a3 = ins[15:11]; wd = hilo; end
    end else if (op inside {[8:14]}) begin a3 = ins[20:16]; wd = c; end
    else if (op == 15) begin a3 = ins[20:16]; wd = ext; end
    else if (op == 35) begin a3 = ins[20:16]; wd = rdw; end
    else if (op == 32) begin a3 = ins[20:16]; wd = (b >= 128) ? (b | 32'hFFFFFF00) : b; end
    else if (op == 36) begin a3 = ins[20:16]; wd = b; end
    else if (op == 33) begin a3 = ins[20:16]; wd = (h >= 32768) ? (h | 32'hFFFF0000) : h; end
    else if (op == 37) begin a3 = ins[20:16]; wd = h; end
    else if (op == 3) begin a3 = 5'd31; wd = pc + 32'd8; end
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] a, input logic [4:0] a3, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
    if (a == a3) return wd;
    return m_regs[a];
  endfunction

  // driver: one W instruction per cycle, expectation pushed, model updated for the next edge
  task automatic drive(input logic [31:0] ins, pc, c, rdw, ext, hilo, input logic [4:0] a1, a2);
    logic [4:0]  a3;
    logic [31:0] wd;
    @(posedge clk);
    #1;
    W_Instr = ins; W_pc = pc; W_C = c; W_RD = rdw; W_EXTout = ext; W_HILO = hilo;
    D_A1 = a1; D_A2 = a2;
    ref_wb(ins, pc, c, rdw, ext, hilo, a3, wd);
    exp_q.push_back({a3, wd, ref_read(a1, a3, wd), ref_read(a2, a3, wd)});
    if (a3 != 5'd0) m_regs[a3] = wd;
  endtask

  task automatic bubble(input logic [4:0] a1, a2);
    drive(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, a1, a2);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("W_A3", {27'd0, W_A3}, {27'd0, e[100:96]});
      check("W_WD", W_WD, e[95:64]);
      check("D_RD1", D_RD1, e[63:32]);
      check("D_RD2", D_RD2, e[31:0]);
    end
  end

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] ops [18];
    logic [5:0] fns [24];
    logic [4:0] rs, rt, rd;
    ops = '{6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h21,
            6'h23, 6'h24, 6'h25, 6'h2B, 6'h04, 6'h02, 6'h03, 6'h3F};
    fns = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B, 6'h08, 6'h09, 6'h10, 6'h12,
            6'h11, 6'h13, 6'h18, 6'h1B};
    rs = 5'($urandom_range(0, 31));
    rt = 5'($urandom_range(0, 31));
    rd = 5'($urandom_range(0, 31));
    if ($urandom_range(0, 1) == 0) return r_ins(fns[$urandom_range(0, 23)], rs, rt, rd);
    return i_ins(ops[$urandom_range(0, 17)], rs, rt, 16'($urandom()));
  endfunction

  initial begin
    logic [31:0] ins;
    logic [4:0]  a1, a2;
    logic [31:0] lb_exp [4];
    n_total = 0;
    n_pass  = 0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    W_Instr = 0; W_pc = 0; W_C = 0; W_RD = 0; W_EXTout = 0; W_HILO = 0;
    D_A1 = 5'd0; D_A2 = 5'd0;
    reset = 1'b0;
    #12;
    D_A1 = 5'd5; D_A2 = 5'd31;
    #1;
    check("reset_rd1", D_RD1, 32'd0);
    check("reset_rd2", D_RD2, 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // ori $5,$0,0x1234: bypass this cycle, array next cycle
    drive(i_ins(6'h0D, 5'd0, 5'd5, 16'h1234), 32'h100, 32'h1234, 0, 0, 0, 5'd5, 5'd5);
    #1 check("ori_bypass", D_RD1, 32'h1234);
    bubble(5'd5, 5'd0);
    #1 check("ori_array", D_RD1, 32'h1234);

    // lb/lh/lhu extension from 0x80FF7F01
    lb_exp = '{32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF80};
    for (int off = 0; off < 4; off++) begin
      drive(i_ins(6'h20, 5'd1, 5'd6, 16'(off)), 32'h200, 32'h1000 + 32'(off), 32'h80FF7F01, 0, 0, 5'd6, 5'd1);
      #1 check("lb_wd", W_WD, lb_exp[off]);
    end
    drive(i_ins(6'h25, 5'd1, 5'd6, 16'h2), 32'h204, 32'h1002, 32'h80FF7F01, 0, 0, 5'd6, 5'd6);
    #1 check("lhu_wd", W_WD, 32'h000080FF);
    drive(i_ins(6'h21, 5'd1, 5'd6, 16'h0), 32'h208, 32'h1000, 32'h80FF7F01, 0, 0, 5'd6, 5'd6);
    #1 check("lh_wd", W_WD, 32'h00007F01);

    // jal
    drive({6'h03, 26'h0000C10}, 32'h00003000, 0, 0, 0, 0, 5'd31, 5'd0);
    #1 check("jal_a3", {27'd0, W_A3}, 32'd31);
    check("jal_wd", W_WD, 32'h00003008);
    bubble(5'd31, 5'd6);
    #1 check("jal_reg31", D_RD1, 32'h00003008);

    // writes to $0 are dropped
    drive(r_ins(6'h21, 5'd1, 5'd2, 5'd0), 32'h300, 32'hDEADBEEF, 0, 0, 0, 5'd0, 5'd0);
    #1 check("addu0_a3", {27'd0, W_A3}, 32'd0);
    check("addu0_rd1", D_RD1, 32'd0);
    bubble(5'd0, 5'd5);

    // sw, beq write nothing; mflo $7
    drive(i_ins(6'h2B, 5'd1, 5'd5, 16'h4), 32'h304, 32'h5555, 32'h77, 0, 0, 5'd5, 5'd6);
    #1 check("sw_a3", {27'd0, W_A3}, 32'd0);
    drive(i_ins(6'h04, 5'd5, 5'd6, 16'h8), 32'h308, 32'h9999, 0, 0, 0, 5'd5, 5'd6);
    #1 check("beq_a3", {27'd0, W_A3}, 32'd0);
    drive(r_ins(6'h12, 5'd0, 5'd0, 5'd7), 32'h30C, 0, 0, 0, 32'h55AA, 5'd0, 5'd0);
    bubble(5'd7, 5'd5);
    #1 check("mflo_reg7", D_RD1, 32'h000055AA);
    check("reg5_kept", D_RD2, 32'h1234);

    // random stream
    for (int n = 0; n < 400; n++) begin
      ins = rand_ins();
      a1 = ($urandom_range(0, 3) == 0) ? ins[20:16] : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? ins[15:11] : 5'($urandom_range(0, 31));
      drive(ins, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), a1, a2);
    end

    // mid-cycle reset clears everything before any edge
    bubble(5'd5, 5'd7);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    #1 check("midreset_rd1", D_RD1, 32'd0);
    check("midreset_rd2", D_RD2, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    bubble(5'd6, 5'd31);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (exp_q.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
